// File: rtl/drop_position_if.sv
// Request/response bus of the drop-position engine.
//   master : requester/consumer side (drives req_*, selected_column, rsp_ready)
//   slave  : engine side (drives req_ready, rsp_valid, column_position, rsp_error)
interface drop_position_if #(
    parameter int unsigned COLS  = 4,
    parameter int unsigned POS_W = 5
);
    logic             req_valid;
    logic             req_undo;
    logic [COLS-1:0]  selected_column;
    logic             req_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [POS_W-1:0] column_position;
    logic             rsp_error;

    modport master (
        output req_valid, req_undo, selected_column, rsp_ready,
        input  req_ready, rsp_valid, column_position, rsp_error
    );

    modport slave (
        input  req_valid, req_undo, selected_column, rsp_ready,
        output req_ready, rsp_valid, column_position, rsp_error
    );
endinterface

// File: rtl/drop_position_calc.sv
// Connect-4 drop-position engine: one fill counter per column, turns an
// active-low one-hot column select into a linear cell index, supports undo,
// column/board-full flags and synchronous board clear.
// Ports:
//   clk, reset_n  : clock, async active-low reset
//   clear         : sync board clear (wins over any request)
//   bus           : drop_position_if slave (request/response handshake)
//   col_full      : per-column full flags (registered)
//   board_full    : all columns full (registered)
module drop_position_calc #(
    parameter int unsigned ROWS  = 4,
    parameter int unsigned COLS  = 4,
    parameter int unsigned POS_W = $clog2(ROWS*COLS+1),
    parameter int unsigned CNT_W = $clog2(ROWS+1)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clear,
    drop_position_if.slave  bus,
    output logic [COLS-1:0] col_full,
    output logic            board_full
);
    localparam int unsigned IDX_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [POS_W-1:0] NO_POS = '1;

    typedef enum logic {IDLE, RESP} state_t;

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q   [COLS];
    logic [CNT_W-1:0] cnt_nxt [COLS];
    logic [POS_W-1:0] pos_q, pos_nxt;
    logic             err_q, err_nxt;
    logic             valid_q, valid_nxt;
    logic             ready_en_q;
    logic [COLS-1:0]  full_nxt;
    logic [COLS-1:0]  sel_n;
    logic             legal;
    logic [IDX_W-1:0] sel_idx;
    logic [CNT_W-1:0] n;
    logic             req_ready_c;

    // Ready only once out of reset, in IDLE and not clearing.
    assign req_ready_c         = ready_en_q && (state_q == IDLE) && !clear;
    assign bus.req_ready       = req_ready_c;
    assign bus.rsp_valid       = valid_q;
    assign bus.column_position = pos_q;
    assign bus.rsp_error       = err_q;

    // Next-state / next-output logic.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        pos_nxt   = pos_q;
        err_nxt   = err_q;
        valid_nxt = valid_q;
        full_nxt  = '0;
        sel_n     = ~bus.selected_column;
        legal     = ($countones(sel_n) == 1);
        sel_idx   = '0;
        for (int unsigned i = 0; i < COLS; i++) begin
            if (sel_n[i]) sel_idx = IDX_W'(i);
        end
        n = cnt_q[sel_idx];

        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_c) begin
                    state_nxt = RESP;
                    valid_nxt = 1'b1;
                    if (legal && !bus.req_undo && (n < CNT_W'(ROWS))) begin
                        pos_nxt          = POS_W'(n) * POS_W'(COLS) + POS_W'(sel_idx);
                        cnt_nxt[sel_idx] = n + CNT_W'(1);
                        err_nxt          = 1'b0;
                    end else if (legal && bus.req_undo && (n != '0)) begin
                        pos_nxt          = POS_W'(n - CNT_W'(1)) * POS_W'(COLS) + POS_W'(sel_idx);
                        cnt_nxt[sel_idx] = n - CNT_W'(1);
                        err_nxt          = 1'b0;
                    end else begin
                        pos_nxt = NO_POS;
                        err_nxt = 1'b1;
                    end
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Clear discards any pending response and empties the board.
        if (clear) begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
            for (int unsigned i = 0; i < COLS; i++) cnt_nxt[i] = '0;
        end

        for (int unsigned i = 0; i < COLS; i++) begin
            full_nxt[i] = (cnt_nxt[i] == CNT_W'(ROWS));
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pos_q      <= NO_POS;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
            ready_en_q <= 1'b0;
            col_full   <= '0;
            board_full <= 1'b0;
            for (int unsigned i = 0; i < COLS; i++) cnt_q[i] <= '0;
        end else begin
            state_q    <= state_nxt;
            pos_q      <= pos_nxt;
            err_q      <= err_nxt;
            valid_q    <= valid_nxt;
            ready_en_q <= 1'b1;
            col_full   <= full_nxt;
            board_full <= &full_nxt;
            cnt_q      <= cnt_nxt;
        end
    end
endmodule

// File: tb/tb_drop_position_calc.sv
// Directed bench for drop_position_calc (ROWS=COLS=4).
module tb_drop_position_calc;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clear = 1'b0;
    logic [3:0] col_full;
    logic board_full;

    int total = 0;
    int passed = 0;

    drop_position_if #(.COLS(4), .POS_W(5)) bif ();

    drop_position_calc #(.ROWS(4), .COLS(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .bus        (bif.slave),
        .col_full   (col_full),
        .board_full (board_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       undo;
        bit [3:0] sel;
        bit [4:0] exp_pos;
        bit       exp_err;
        bit [3:0] exp_full;
        bit       exp_bfull;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    // Issue one request, check the response right after the accept edge, then consume it.
    task automatic do_req(input bit undo, input bit [3:0] sel, input bit [4:0] ep,
                          input bit ee, input bit [3:0] ef, input bit eb);
        int k = 0;
        @(negedge clk);
        bif.req_valid       = 1'b1;
        bif.req_undo        = undo;
        bif.selected_column = sel;
        while (!bif.req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) begin
            chk("ready_timeout", 32'(bif.req_ready), 32'd1);
            bif.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bif.req_valid = 1'b0;
        chk("rsp_valid", 32'(bif.rsp_valid), 32'd1);
        chk("position", 32'(bif.column_position), 32'(ep));
        chk("rsp_error", 32'(bif.rsp_error), 32'(ee));
        chk("col_full", 32'(col_full), 32'(ef));
        chk("board_full", 32'(board_full), 32'(eb));
        @(negedge clk);
        bif.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bif.rsp_ready = 1'b0;
        chk("rsp_drop", 32'(bif.rsp_valid), 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        bif.req_valid       = 1'b0;
        bif.req_undo        = 1'b0;
        bif.selected_column = 4'b1111;
        bif.rsp_ready       = 1'b0;

        // Drops/undos on column 0..3, illegal selects, filling to a full board.
        vecs = '{
            '{0, 4'b1110,  0, 0, 4'b0000, 0},
            '{0, 4'b1110,  4, 0, 4'b0000, 0},
            '{0, 4'b1110,  8, 0, 4'b0000, 0},
            '{0, 4'b1110, 12, 0, 4'b0001, 0},
            '{0, 4'b1110, 31, 1, 4'b0001, 0},
            '{0, 4'b0111,  3, 0, 4'b0001, 0},
            '{0, 4'b1101,  1, 0, 4'b0001, 0},
            '{1, 4'b0111,  3, 0, 4'b0001, 0},
            '{1, 4'b0111, 31, 1, 4'b0001, 0},
            '{0, 4'b1111, 31, 1, 4'b0001, 0},
            '{0, 4'b1100, 31, 1, 4'b0001, 0},
            '{0, 4'b1101,  5, 0, 4'b0001, 0},
            '{0, 4'b0111,  3, 0, 4'b0001, 0},
            '{0, 4'b1101,  9, 0, 4'b0001, 0},
            '{0, 4'b1101, 13, 0, 4'b0011, 0},
            '{0, 4'b1011,  2, 0, 4'b0011, 0},
            '{0, 4'b1011,  6, 0, 4'b0011, 0},
            '{0, 4'b1011, 10, 0, 4'b0011, 0},
            '{0, 4'b1011, 14, 0, 4'b0111, 0},
            '{0, 4'b0111,  7, 0, 4'b0111, 0},
            '{0, 4'b0111, 11, 0, 4'b0111, 0},
            '{0, 4'b0111, 15, 0, 4'b1111, 1},
            '{0, 4'b1011, 31, 1, 4'b1111, 1},
            '{1, 4'b1110, 12, 0, 4'b1110, 0},
            '{0, 4'b1110, 12, 0, 4'b1111, 1}
        };

        #12;
        chk("reset_pos", 32'(bif.column_position), 32'd31);
        chk("reset_valid", 32'(bif.rsp_valid), 32'd0);
        chk("reset_full", 32'(col_full), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", 32'(bif.req_ready), 32'd1);

        foreach (vecs[i])
            do_req(vecs[i].undo, vecs[i].sel, vecs[i].exp_pos, vecs[i].exp_err,
                   vecs[i].exp_full, vecs[i].exp_bfull);

        // Clear with a simultaneous request: not accepted, flags drop.
        @(negedge clk);
        clear = 1'b1;
        bif.req_valid = 1'b1;
        bif.req_undo = 1'b0;
        bif.selected_column = 4'b1110;
        #1;
        chk("ready_in_clear", 32'(bif.req_ready), 32'd0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        bif.req_valid = 1'b0;
        chk("clear_valid", 32'(bif.rsp_valid), 32'd0);
        chk("clear_full", 32'(col_full), 32'd0);
        chk("clear_bfull", 32'(board_full), 32'd0);
        do_req(0, 4'b1011, 2, 0, 4'b0000, 0);

        // Back-pressure: response held 5 clocks, new requests ignored.
        @(negedge clk);
        bif.req_valid = 1'b1;
        bif.req_undo = 1'b0;
        bif.selected_column = 4'b1110;
        @(posedge clk);
        #1;
        bif.selected_column = 4'b0111;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("hold_valid", 32'(bif.rsp_valid), 32'd1);
            chk("hold_pos", 32'(bif.column_position), 32'd0);
            chk("hold_ready", 32'(bif.req_ready), 32'd0);
        end
        bif.req_valid = 1'b0;
        bif.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bif.rsp_ready = 1'b0;
        chk("hold_release", 32'(bif.rsp_valid), 32'd0);
        do_req(0, 4'b0111, 3, 0, 4'b0000, 0);
        do_req(0, 4'b1110, 4, 0, 4'b0000, 0);

        // Clear while a response is pending discards it.
        @(negedge clk);
        bif.req_valid = 1'b1;
        bif.selected_column = 4'b1101;
        @(posedge clk);
        #1;
        bif.req_valid = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("clear_in_resp", 32'(bif.rsp_valid), 32'd0);
        do_req(0, 4'b1110, 0, 0, 4'b0000, 0);

        // Asynchronous reset during a pending response.
        @(negedge clk);
        bif.req_valid = 1'b1;
        bif.selected_column = 4'b1110;
        @(posedge clk);
        #1;
        bif.req_valid = 1'b0;
        chk("pre_reset_valid", 32'(bif.rsp_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_valid", 32'(bif.rsp_valid), 32'd0);
        chk("async_pos", 32'(bif.column_position), 32'd31);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset2", 32'(bif.req_ready), 32'd1);
        do_req(0, 4'b1110, 0, 0, 4'b0000, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
